// File: rtl/synth_pkg.sv
`default_nettype none
// ============================================================================
// Module   : synth_pkg
// Brief    : Shared widths, clocking constants, FSM encoding and FCW helper
// Revision : 1.0 - initial release
// ============================================================================
package synth_pkg;

  localparam int  FCW_W      = 24;
  localparam int  NOTE_W     = 7;
  localparam int  NOTE_COUNT = 1 << NOTE_W;
  localparam int  PA_CLK_HZ  = 5_000_000;
  localparam real SEMITONE   = 1.0594630943592953;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOOKUP = 2'd1,
    S_GLIDE  = 2'd2,
    S_PLAY   = 2'd3
  } state_t;

  // Equal-tempered pitch (A4 = note 69 = 440 Hz) scaled to phase_accu FCW units.
  // Evaluated only at elaboration to fill the note ROM.
  function automatic logic [FCW_W-1:0] note_to_fcw(input int n);
    real f;
    f = 440.0 * $itor(1 << FCW_W) / $itor(PA_CLK_HZ);
    for (int i = 69; i < n; i++) f = f * SEMITONE;
    for (int i = n; i < 69; i++) f = f / SEMITONE;
    return FCW_W'($rtoi(f + 0.5));
  endfunction

endpackage
`default_nettype wire

// File: rtl/note_fcw_rom.sv
`default_nettype none
// ============================================================================
// Module   : note_fcw_rom
// Brief    : 128-entry registered note-number to FCW lookup ROM
// Revision : 1.0 - initial release
// ============================================================================
module note_fcw_rom
  import synth_pkg::*;
(
  input  logic              i_clk50mhz,
  input  logic              i_en,
  input  logic [NOTE_W-1:0] i_addr,
  output logic [FCW_W-1:0]  o_data
);

  logic [FCW_W-1:0] w_table [0:NOTE_COUNT-1];
  logic [FCW_W-1:0] r_data;

  for (genvar n = 0; n < NOTE_COUNT; n++) begin : g_rom
    localparam logic [FCW_W-1:0] c_entry = note_to_fcw(n);
    assign w_table[n] = c_entry;
  end

  // Output holds between lookups so the top can read it one cycle later.
  always_ff @(posedge i_clk50mhz) begin
    if (i_en) r_data <= w_table[i_addr];
  end

  assign o_data = r_data;

endmodule
`default_nettype wire

// File: rtl/note_fcw_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : note_fcw_sequencer
// Brief    : Note event FSM driving phase_accu FCW with legato glide and gate
// Revision : 1.0 - initial release
// ============================================================================
module note_fcw_sequencer
  import synth_pkg::*;
#(
  parameter int GLIDE_DIV  = 5000,
  parameter int STEP_SHIFT = 4
) (
  input  logic              i_clk50mhz,
  input  logic              i_rst,
  input  logic              i_note_valid,
  output logic              o_note_ready,
  input  logic [NOTE_W-1:0] i_note,
  input  logic              i_note_on,
  input  logic              i_glide_en,
  output logic [FCW_W-1:0]  o_fcw,
  output logic              o_gate,
  output logic              o_busy
);

  localparam int TICK_W = (GLIDE_DIV > 1) ? $clog2(GLIDE_DIV) : 1;

  state_t             r_state, w_state_nxt;
  logic [NOTE_W-1:0]  r_note, w_note_nxt;
  logic               r_glide, w_glide_nxt;
  logic [FCW_W-1:0]   r_fcw, w_fcw_nxt;
  logic [FCW_W-1:0]   r_target, w_target_nxt;
  logic               r_gate, w_gate_nxt;
  logic               r_busy, w_busy_nxt;
  logic [TICK_W-1:0]  r_tick, w_tick_nxt;

  logic               w_accept;
  logic               w_rom_en;
  logic               w_tick_wrap;
  logic [FCW_W-1:0]   w_rom_q;
  logic signed [FCW_W:0] w_diff;
  logic [FCW_W:0]     w_abs;
  logic [FCW_W:0]     w_step_raw;
  logic [FCW_W:0]     w_step;

  note_fcw_rom u_rom (
    .i_clk50mhz (i_clk50mhz),
    .i_en       (w_rom_en),
    .i_addr     (i_note),
    .o_data     (w_rom_q)
  );

  assign o_note_ready = ~i_rst & (r_state != S_LOOKUP);
  assign w_accept     = i_note_valid & o_note_ready;
  assign w_rom_en     = w_accept & i_note_on;
  assign w_tick_wrap  = (r_tick == TICK_W'(GLIDE_DIV - 1));

  // Glide step: 1/2^STEP_SHIFT of the remaining distance, never below 1 LSB.
  assign w_diff     = $signed({1'b0, r_target}) - $signed({1'b0, r_fcw});
  assign w_abs      = w_diff[FCW_W] ? $unsigned(-w_diff) : $unsigned(w_diff);
  assign w_step_raw = w_abs >> STEP_SHIFT;
  assign w_step     = (w_step_raw == '0) ? (FCW_W+1)'(1) : w_step_raw;

  always_comb begin
    w_state_nxt  = r_state;
    w_note_nxt   = r_note;
    w_glide_nxt  = r_glide;
    w_fcw_nxt    = r_fcw;
    w_target_nxt = r_target;
    w_gate_nxt   = r_gate;
    w_busy_nxt   = r_busy;
    w_tick_nxt   = r_tick;

    case (r_state)
      S_LOOKUP: begin
        w_target_nxt = w_rom_q;
        if (!r_gate || !r_glide || (w_rom_q == r_fcw)) begin
          w_fcw_nxt   = w_rom_q;
          w_gate_nxt  = 1'b1;
          w_busy_nxt  = 1'b0;
          w_state_nxt = S_PLAY;
        end else begin
          w_busy_nxt  = 1'b1;
          w_tick_nxt  = '0;
          w_state_nxt = S_GLIDE;
        end
      end
      S_GLIDE: begin
        if (w_tick_wrap) begin
          w_tick_nxt = '0;
          if (w_abs <= w_step) begin
            w_fcw_nxt   = r_target;
            w_busy_nxt  = 1'b0;
            w_state_nxt = S_PLAY;
          end else if (w_diff[FCW_W]) begin
            w_fcw_nxt = r_fcw - w_step[FCW_W-1:0];
          end else begin
            w_fcw_nxt = r_fcw + w_step[FCW_W-1:0];
          end
        end else begin
          w_tick_nxt = r_tick + 1'b1;
        end
      end
      default: ;
    endcase

    // Accepted events pre-empt a coincident glide step; ignored note-offs do not.
    if (w_accept) begin
      if (i_note_on) begin
        w_note_nxt  = i_note;
        w_glide_nxt = i_glide_en;
        w_fcw_nxt   = r_fcw;
        w_busy_nxt  = r_busy;
        w_tick_nxt  = r_tick;
        w_state_nxt = S_LOOKUP;
      end else if ((i_note == r_note) && r_gate) begin
        w_fcw_nxt   = r_fcw;
        w_gate_nxt  = 1'b0;
        w_busy_nxt  = 1'b0;
        w_state_nxt = S_IDLE;
      end
    end
  end

  always_ff @(posedge i_clk50mhz) begin
    if (i_rst) begin
      r_state  <= S_IDLE;
      r_note   <= '0;
      r_glide  <= 1'b0;
      r_fcw    <= '0;
      r_target <= '0;
      r_gate   <= 1'b0;
      r_busy   <= 1'b0;
      r_tick   <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_note   <= w_note_nxt;
      r_glide  <= w_glide_nxt;
      r_fcw    <= w_fcw_nxt;
      r_target <= w_target_nxt;
      r_gate   <= w_gate_nxt;
      r_busy   <= w_busy_nxt;
      r_tick   <= w_tick_nxt;
    end
  end

  assign o_fcw  = r_fcw;
  assign o_gate = r_gate;
  assign o_busy = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_note_fcw_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_note_fcw_sequencer
// Brief    : Directed and randomized self-checking bench for note_fcw_sequencer
// Revision : 1.0 - initial release
// ============================================================================
module tb_note_fcw_sequencer;

  localparam int GLIDE_DIV  = 4;
  localparam int STEP_SHIFT = 4;

  logic        clk;
  logic        i_rst;
  logic        i_note_valid;
  logic        o_note_ready;
  logic [6:0]  i_note;
  logic        i_note_on;
  logic        i_glide_en;
  logic [23:0] o_fcw;
  logic        o_gate;
  logic        o_busy;

  int n_chk = 0;
  int n_err = 0;

  // Reference model: pending lookup flag plus glide bookkeeping in plain integers.
  bit m_pend, m_pend_glide, m_gate, m_busy, m_gliding;
  int m_pend_note, m_cur_note, m_fcw, m_target, m_ticks;

  note_fcw_sequencer #(
    .GLIDE_DIV  (GLIDE_DIV),
    .STEP_SHIFT (STEP_SHIFT)
  ) dut (
    .i_clk50mhz   (clk),
    .i_rst        (i_rst),
    .i_note_valid (i_note_valid),
    .o_note_ready (o_note_ready),
    .i_note       (i_note),
    .i_note_on    (i_note_on),
    .i_glide_en   (i_glide_en),
    .o_fcw        (o_fcw),
    .o_gate       (o_gate),
    .o_busy       (o_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int rom_ref(input int n);
    real f;
    f = 440.0 * (2.0 ** ((n - 69) / 12.0)) * 16777216.0 / 5.0e6;
    return $rtoi(f + 0.5);
  endfunction

  task automatic model_reset();
    m_pend = 0; m_pend_glide = 0; m_gate = 0; m_busy = 0; m_gliding = 0;
    m_pend_note = 0; m_cur_note = 0; m_fcw = 0; m_target = 0; m_ticks = 0;
  endtask

  task automatic model_glide();
    int d, a, s;
    if (m_gliding) begin
      m_ticks++;
      if (m_ticks == GLIDE_DIV) begin
        m_ticks = 0;
        d = m_target - m_fcw;
        a = (d < 0) ? -d : d;
        s = a >> STEP_SHIFT;
        if (s < 1) s = 1;
        if (a <= s) begin
          m_fcw = m_target; m_busy = 0; m_gliding = 0;
        end else begin
          m_fcw = (d < 0) ? m_fcw - s : m_fcw + s;
        end
      end
    end
  endtask

  task automatic model_step();
    int tgt;
    if (i_rst) begin
      model_reset();
    end else if (m_pend) begin
      tgt = rom_ref(m_pend_note);
      m_target = tgt;
      m_pend = 0;
      if (!m_gate || !m_pend_glide || tgt == m_fcw) begin
        m_fcw = tgt; m_gate = 1; m_busy = 0; m_gliding = 0;
      end else begin
        m_busy = 1; m_gliding = 1; m_ticks = 0;
      end
    end else if (i_note_valid && i_note_on) begin
      m_pend = 1; m_pend_note = int'(i_note); m_pend_glide = i_glide_en;
      m_cur_note = int'(i_note);
    end else if (i_note_valid && int'(i_note) == m_cur_note && m_gate) begin
      m_gate = 0; m_busy = 0; m_gliding = 0;
    end else begin
      model_glide();
    end
  endtask

  // One clock: ready checked before the edge, registered outputs just after.
  task automatic cycle();
    #1;
    check_eq("ready", {31'b0, o_note_ready}, {31'b0, (!i_rst && !m_pend)});
    @(posedge clk);
    model_step();
    #1;
    check_eq("fcw", {8'b0, o_fcw}, m_fcw);
    check_eq("gate", {31'b0, o_gate}, {31'b0, m_gate});
    check_eq("busy", {31'b0, o_busy}, {31'b0, m_busy});
  endtask

  task automatic send(input int note, input bit on, input bit glide);
    i_note_valid = 1'b1;
    i_note       = 7'(note);
    i_note_on    = on;
    i_glide_en   = glide;
    cycle();
    i_note_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) cycle();
  endtask

  initial begin
    int last, since, held;
    model_reset();
    i_rst = 1'b1; i_note_valid = 1'b0; i_note = '0; i_note_on = 1'b0; i_glide_en = 1'b0;

    // 1: reset values, ready follows reset
    idle(3);
    check_eq("t1_fcw", {8'b0, o_fcw}, 32'h0);
    check_eq("t1_gate", {31'b0, o_gate}, 32'h0);
    check_eq("t1_busy", {31'b0, o_busy}, 32'h0);
    check_eq("t1_ready", {31'b0, o_note_ready}, 32'h0);
    i_rst = 1'b0;
    #1 check_eq("t1_ready_rel", {31'b0, o_note_ready}, 32'h1);

    // 2: note-on from idle loads directly after one lookup cycle
    send(69, 1, 0);
    check_eq("t2_lookup_ready", {31'b0, o_note_ready}, 32'h0);
    check_eq("t2_fcw_hold", {8'b0, o_fcw}, 32'h0);
    cycle();
    check_eq("t2_fcw", {8'b0, o_fcw}, 32'h0005C4);
    check_eq("t2_gate", {31'b0, o_gate}, 32'h1);
    check_eq("t2_ready", {31'b0, o_note_ready}, 32'h1);

    // 3: legato glide 69 -> 81
    send(81, 1, 1);
    cycle();
    check_eq("t3_busy", {31'b0, o_busy}, 32'h1);
    last = int'(o_fcw);
    since = 0;
    for (int k = 0; k < 400 && o_busy; k++) begin
      cycle();
      since++;
      check_eq("t3_gate", {31'b0, o_gate}, 32'h1);
      if (int'(o_fcw) != last) begin
        check_eq("t3_rise", {31'b0, (int'(o_fcw) > last)}, 32'h1);
        check_eq("t3_period", since, GLIDE_DIV);
        since = 0;
        last = int'(o_fcw);
      end
    end
    check_eq("t3_timeout", {31'b0, o_busy}, 32'h0);
    check_eq("t3_final", {8'b0, o_fcw}, 32'h000B89);

    // 4: note-off handling
    send(60, 0, 0);
    check_eq("t4_ignored", {31'b0, o_gate}, 32'h1);
    send(81, 0, 0);
    check_eq("t4_gate_off", {31'b0, o_gate}, 32'h0);
    check_eq("t4_fcw_hold", {8'b0, o_fcw}, 32'h000B89);

    // 5: note-off mid-glide freezes FCW; next note loads without glide
    send(69, 1, 0);
    cycle();
    send(81, 1, 1);
    cycle();
    idle(10);
    held = int'(o_fcw);
    check_eq("t5_mid", {31'b0, (held > 32'h5C4 && held < 32'hB89)}, 32'h1);
    send(81, 0, 0);
    check_eq("t5_gate", {31'b0, o_gate}, 32'h0);
    check_eq("t5_busy", {31'b0, o_busy}, 32'h0);
    idle(6);
    check_eq("t5_frozen", {8'b0, o_fcw}, held);
    send(60, 1, 1);
    cycle();
    check_eq("t5_load60", {8'b0, o_fcw}, rom_ref(60));
    check_eq("t5_no_glide", {31'b0, o_busy}, 32'h0);

    // 6: reset mid-glide with a pending event
    send(81, 1, 1);
    cycle();
    idle(5);
    check_eq("t6_gliding", {31'b0, o_busy}, 32'h1);
    i_rst = 1'b1; i_note_valid = 1'b1; i_note = 7'd30; i_note_on = 1'b1; i_glide_en = 1'b0;
    cycle();
    check_eq("t6_fcw", {8'b0, o_fcw}, 32'h0);
    check_eq("t6_gate", {31'b0, o_gate}, 32'h0);
    check_eq("t6_busy", {31'b0, o_busy}, 32'h0);
    i_rst = 1'b0; i_note_valid = 1'b0;
    cycle();
    check_eq("t6_no_accept", {31'b0, o_note_ready}, 32'h1);
    check_eq("t6_idle_gate", {31'b0, o_gate}, 32'h0);

    // Randomized traffic against the model
    for (int k = 0; k < 4000; k++) begin
      i_rst        = ($urandom_range(0, 799) == 0);
      i_note_valid = ($urandom_range(0, 24) == 0);
      i_note_on    = ($urandom_range(0, 9) < 6);
      i_glide_en   = ($urandom_range(0, 3) != 0);
      if (!i_note_on && $urandom_range(0, 1) == 1) i_note = 7'(m_cur_note);
      else i_note = 7'($urandom_range(0, 127));
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
